lift_dispatch: RTL and testbench
================================

# lift_dispatch

Call scheduler for the elevator controller. Latches floor call requests into a pending-call register and picks the next target floor using a SCAN (sweep-direction) policy. Issues that target to the lift FSM with a valid/arrive handshake. Sits between the request inputs and the lift FSM, replacing strict FIFO ordering of requests with direction-aware scheduling.

## Interface

Parameters:
- NFLOOR, 4, number of floors, legal range 2..8.
- FW, 2, floor index width, equal to clog2(NFLOOR).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- call_req  in  NFLOOR  multi-hot; bit i high for one or more cycles means a call at floor i (hall and car calls merged).
- cur_floor  in  FW  current floor reported by the lift FSM. Valid every cycle.
- arrive  in  1  single-cycle pulse from the lift FSM: the lift has stopped at tgt_floor.
- tgt_valid  out  1  target issued; held high until arrive.
- tgt_floor  out  FW  target floor; stable while tgt_valid is high.
- dir  out  2  sweep direction: 00 idle, 01 up, 10 down (11 never driven).
- served  out  1  single-cycle pulse when a pending call is cleared.
- pending  out  NFLOOR  current pending-call register.

## Operation

- Reset values (rst_n low at a clock edge): state IDLE, pending=0, tgt_valid=0, tgt_floor=0, dir=00, served=0. call_req and arrive are ignored in the reset cycle.
- pending update each cycle: pending_next = (pending | call_req) & ~clear_mask.
  - clear_mask is the one-hot of the floor being cleared in that cycle (arrive or same-floor service), else 0.
  - When a clear and a call to the same floor coincide, the clear wins.
- States:
  - IDLE: if pending != 0, go to SELECT; else stay. dir=00.
  - SELECT: one-cycle decision, evaluated in this order:
    1. If pending[cur_floor] is set: clear it, pulse served, stay in SELECT if other bits remain, else go to IDLE. No target is issued.
    2. Else, if dir=01 (up): target = lowest pending floor above cur_floor. If none exists, target = highest pending floor below, and dir becomes 10.
    3. Else, if dir=10 (down): the mirror image of rule 2.
    4. Else (dir=00): target = nearest pending floor by absolute distance; a tie goes up. dir is set toward the target.
    - When rule 2, 3 or 4 selects a target, register tgt_floor, set tgt_valid=1 and go to BUSY.
  - BUSY: tgt_valid=1 and tgt_floor held stable. New calls are latched into pending but do not preempt the target. On arrive: clear pending[tgt_floor], pulse served, drop tgt_valid, and go to SELECT if the remaining pending != 0, else go to IDLE with dir=00.
- arrive outside BUSY is ignored.
- cur_floor is sampled only in SELECT.

## Timing

- Call-to-issue latency from IDLE, with call_req high in cycle 0:
  - pending bit is high in cycle 1;
  - state is SELECT in cycle 2;
  - tgt_valid=1 in cycle 3.
- arrive in cycle n: served=1 and tgt_valid=0 in cycle n+1, state SELECT in n+1, and the next tgt_valid=1 no earlier than n+2.
- Same-floor service: served pulses in the cycle after SELECT. Each SELECT cycle clears at most one floor.
- served is exactly one cycle wide per cleared call. Two calls are never cleared in the same cycle.
- tgt_floor must not change while tgt_valid=1.
- Reset mid-operation (any state): the next cycle shows the reset values. An arrive pulse arriving during or after that reset cycle is ignored.

## Test plan

- Reset, cur_floor=0, call_req=4'b0100 for 1 cycle -> pending=0100 in cycle 1, tgt_valid=1 with tgt_floor=2 and dir=01 in cycle 3. Then arrive pulse -> served=1, pending=0, state IDLE, dir=00.
- Sweep reversal: dir=01, cur_floor=1, pending=4'b1001 -> tgt_floor=3. After arrive with cur_floor=3 -> tgt_floor=0 and dir=10.
- Tie break: IDLE, cur_floor=1, call_req=4'b0101 -> tgt_floor=2, dir=01.
- Same floor: IDLE, cur_floor=2, call_req=4'b0100 -> served pulse in cycle 3, tgt_valid stays 0, ends in IDLE.
- Simultaneous events: in BUSY with tgt_floor=3, arrive and call_req=4'b1010 in the same cycle -> pending=4'b0010 (bit 3 cleared, bit 1 latched), next target is 1.
- Reset mid-BUSY: rst_n low for one cycle while tgt_valid=1 -> next cycle tgt_valid=0, pending=0, dir=00. A following arrive produces no served pulse.

Source files
------------

// File: rtl/lift_dispatch.sv
// lift_dispatch
// Call scheduler for the elevator controller. Floor calls are latched into a
// pending-call register. The next target floor is chosen by a SCAN policy:
// keep sweeping in the current direction, reverse only when nothing is left
// ahead. The target goes to the lift FSM over a valid/arrive handshake.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      synchronous active-low reset
//   call_req   multi-hot floor calls (hall and car merged)
//   cur_floor  current floor from the lift FSM (sampled in SELECT only)
//   arrive     one-cycle pulse: lift stopped at tgt_floor
//   tgt_valid  target issued, held until arrive
//   tgt_floor  target floor, stable while tgt_valid
//   dir        sweep direction: 00 idle, 01 up, 10 down
//   served     one-cycle pulse per cleared call
//   pending    pending-call register
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no pending calls, dir forced to idle
// SELECT | one-cycle decision: serve the current floor or pick a target
// BUSY   | target issued, waiting for arrive; new calls only latched
module lift_dispatch #(
  parameter int NFLOOR = 4,
  parameter int FW     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NFLOOR-1:0] call_req,
  input  logic [FW-1:0]     cur_floor,
  input  logic              arrive,
  output logic              tgt_valid,
  output logic [FW-1:0]     tgt_floor,
  output logic [1:0]        dir,
  output logic              served,
  output logic [NFLOOR-1:0] pending
);

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DN   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_BUSY   = 2'd2
  } state_t;

  state_t            r_state;
  logic [NFLOOR-1:0] r_pending;
  logic              r_tgt_valid;
  logic [FW-1:0]     r_tgt_floor;
  logic [1:0]        r_dir;
  logic              r_served;

  logic              w_up_found;
  logic [FW-1:0]     w_up_tgt;
  logic              w_dn_found;
  logic [FW-1:0]     w_dn_tgt;
  logic [NFLOOR-1:0] w_cur_oh;
  logic [NFLOOR-1:0] w_tgt_oh;
  logic              w_here;
  logic [FW-1:0]     w_up_dist;
  logic [FW-1:0]     w_dn_dist;
  logic              w_near_up;
  logic [NFLOOR-1:0] w_clear_mask;
  logic [NFLOOR-1:0] w_pending_next;

  // Candidate search around cur_floor. The one-hot decodes are built by
  // comparison so an out-of-range floor code simply matches nothing.
  always_comb begin
    w_up_found = 1'b0;
    w_up_tgt   = '0;
    w_dn_found = 1'b0;
    w_dn_tgt   = '0;
    w_cur_oh   = '0;
    w_tgt_oh   = '0;
    // descending scan: last hit is the lowest floor above cur_floor
    for (int i = NFLOOR - 1; i >= 0; i--) begin
      if (r_pending[i] && (i > int'(cur_floor))) begin
        w_up_found = 1'b1;
        w_up_tgt   = FW'(i);
      end
    end
    // ascending scan: last hit is the highest floor below cur_floor
    for (int i = 0; i < NFLOOR; i++) begin
      if (r_pending[i] && (i < int'(cur_floor))) begin
        w_dn_found = 1'b1;
        w_dn_tgt   = FW'(i);
      end
      if (i == int'(cur_floor))   w_cur_oh[i] = 1'b1;
      if (i == int'(r_tgt_floor)) w_tgt_oh[i] = 1'b1;
    end
    w_here    = |(r_pending & w_cur_oh);
    w_up_dist = w_up_tgt - cur_floor;
    w_dn_dist = cur_floor - w_dn_tgt;
    // nearest-floor choice from rest; equal distance goes up
    w_near_up = w_up_found && (!w_dn_found || (w_up_dist <= w_dn_dist));
  end

  // At most one floor is cleared per cycle; a clear beats a same-cycle call.
  always_comb begin
    w_clear_mask = '0;
    if ((r_state == S_SELECT) && w_here)
      w_clear_mask = w_cur_oh;
    else if ((r_state == S_BUSY) && arrive)
      w_clear_mask = w_tgt_oh;
    w_pending_next = (r_pending | call_req) & ~w_clear_mask;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pending   <= '0;
      r_tgt_valid <= 1'b0;
      r_tgt_floor <= '0;
      r_dir       <= DIR_IDLE;
      r_served    <= 1'b0;
    end else begin
      r_pending <= w_pending_next;
      r_served  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_dir <= DIR_IDLE;
          if (|r_pending) r_state <= S_SELECT;
        end

        S_SELECT: begin
          if (w_here) begin
            r_served <= 1'b1;
            if (!(|w_pending_next)) begin
              r_state <= S_IDLE;
              r_dir   <= DIR_IDLE;
            end
          end else if (!w_up_found && !w_dn_found) begin
            // unreachable while pending is non-zero; recover cleanly anyway
            r_state <= S_IDLE;
            r_dir   <= DIR_IDLE;
          end else begin
            r_tgt_valid <= 1'b1;
            r_state     <= S_BUSY;
            if (r_dir == DIR_UP) begin
              if (w_up_found) begin
                r_tgt_floor <= w_up_tgt;
              end else begin
                r_tgt_floor <= w_dn_tgt;
                r_dir       <= DIR_DN;
              end
            end else if (r_dir == DIR_DN) begin
              if (w_dn_found) begin
                r_tgt_floor <= w_dn_tgt;
              end else begin
                r_tgt_floor <= w_up_tgt;
                r_dir       <= DIR_UP;
              end
            end else begin
              if (w_near_up) begin
                r_tgt_floor <= w_up_tgt;
                r_dir       <= DIR_UP;
              end else begin
                r_tgt_floor <= w_dn_tgt;
                r_dir       <= DIR_DN;
              end
            end
          end
        end

        S_BUSY: begin
          if (arrive) begin
            r_served    <= 1'b1;
            r_tgt_valid <= 1'b0;
            if (|w_pending_next) begin
              r_state <= S_SELECT;
            end else begin
              r_state <= S_IDLE;
              r_dir   <= DIR_IDLE;
            end
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_tgt_valid <= 1'b0;
          r_dir       <= DIR_IDLE;
        end
      endcase
    end
  end

  assign tgt_valid = r_tgt_valid;
  assign tgt_floor = r_tgt_floor;
  assign dir       = r_dir;
  assign served    = r_served;
  assign pending   = r_pending;

endmodule

// File: tb/tb_lift_dispatch.sv
module tb_lift_dispatch;

  localparam int NFLOOR = 4;
  localparam int FW     = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NFLOOR-1:0] call_req;
  logic [FW-1:0]     cur_floor;
  logic              arrive;
  logic              tgt_valid;
  logic [FW-1:0]     tgt_floor;
  logic [1:0]        dir;
  logic              served;
  logic [NFLOOR-1:0] pending;

  lift_dispatch #(.NFLOOR(NFLOOR), .FW(FW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .call_req  (call_req),
    .cur_floor (cur_floor),
    .arrive    (arrive),
    .tgt_valid (tgt_valid),
    .tgt_floor (tgt_floor),
    .dir       (dir),
    .served    (served),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    int floor;
    int dirv;
    int lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int f, input int d, input int lat);
    exp_t e;
    e.floor = f;
    e.dirv  = d;
    e.lat   = lat;
    exp_q.push_back(e);
  endtask

  // Ticks until a target is issued; one-cycle stimulus is dropped after the
  // first edge. Latency is counted in edges from the call of this task.
  task automatic expect_issue(input string tag);
    int   n;
    exp_t e;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) begin
        call_req = '0;
        arrive   = 1'b0;
      end
    end while (!tgt_valid && n < 20);
    e = exp_q.pop_front();
    if (!tgt_valid) begin
      chk({tag, "_timeout"}, 32'(tgt_valid), 32'd1);
    end else begin
      chk({tag, "_floor"}, 32'(tgt_floor), 32'(e.floor));
      chk({tag, "_dir"}, 32'(dir), 32'(e.dirv));
      if (e.lat >= 0) chk({tag, "_lat"}, 32'(n), 32'(e.lat));
    end
  endtask

  task automatic do_arrive(input int floor);
    cur_floor = FW'(floor);
    arrive    = 1'b1;
    tick();
    arrive    = 1'b0;
  endtask

  // Target must hold while valid; dir code 11 is never legal.
  logic          prev_valid = 1'b0;
  logic [FW-1:0] prev_floor = '0;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && prev_valid && tgt_valid)
      chk("tgt_stable", 32'(tgt_floor), 32'(prev_floor));
    if (rst_n === 1'b1 && tgt_valid)
      chk("dir_legal", 32'(dir != 2'b11), 32'd1);
    prev_valid = tgt_valid;
    prev_floor = tgt_floor;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    call_req  = '0;
    cur_floor = '0;
    arrive    = 1'b0;
    tick();
    tick();
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_valid", 32'(tgt_valid), 32'd0);
    chk("rst_floor", 32'(tgt_floor), 32'd0);
    chk("rst_dir", 32'(dir), 32'd0);
    chk("rst_served", 32'(served), 32'd0);
    rst_n = 1'b1;

    // basic latency: call at floor 2 from floor 0
    cur_floor = 2'd0;
    call_req  = 4'b0100;
    tick();
    call_req  = '0;
    chk("a_pending_c1", 32'(pending), 32'b0100);
    chk("a_valid_c1", 32'(tgt_valid), 32'd0);
    push_exp(2, 1, 2);
    expect_issue("a_issue");
    do_arrive(2);
    chk("a_served", 32'(served), 32'd1);
    chk("a_valid_drop", 32'(tgt_valid), 32'd0);
    chk("a_pending_clr", 32'(pending), 32'd0);
    chk("a_dir_idle", 32'(dir), 32'd0);
    tick();
    chk("a_served_1cyc", 32'(served), 32'd0);

    // sweep continuation and reversal
    cur_floor = 2'd0;
    call_req  = 4'b0010;
    push_exp(1, 1, 3);
    expect_issue("b_first");
    call_req = 4'b1001;
    tick();
    call_req = '0;
    do_arrive(1);
    chk("b_served1", 32'(served), 32'd1);
    chk("b_pending1", 32'(pending), 32'b1001);
    push_exp(3, 1, 1);
    expect_issue("b_up");
    do_arrive(3);
    chk("b_pending2", 32'(pending), 32'b0001);
    push_exp(0, 2, 1);
    expect_issue("b_reverse");
    do_arrive(0);
    chk("b_pending_end", 32'(pending), 32'd0);
    chk("b_dir_end", 32'(dir), 32'd0);

    // nearest with tie going up, then reversal down
    cur_floor = 2'd1;
    call_req  = 4'b0101;
    push_exp(2, 1, 3);
    expect_issue("c_tie");
    cur_floor = 2'd2;
    arrive    = 1'b1;
    push_exp(0, 2, 2);
    expect_issue("c_next");
    do_arrive(0);
    chk("c_dir_end", 32'(dir), 32'd0);

    // same-floor service: no target, single served pulse in cycle 3
    cur_floor = 2'd2;
    call_req  = 4'b0100;
    tick();
    call_req  = '0;
    tick();
    chk("d_served_c2", 32'(served), 32'd0);
    tick();
    chk("d_served_c3", 32'(served), 32'd1);
    chk("d_valid_c3", 32'(tgt_valid), 32'd0);
    chk("d_pending_c3", 32'(pending), 32'd0);
    tick();
    chk("d_served_c4", 32'(served), 32'd0);
    chk("d_valid_c4", 32'(tgt_valid), 32'd0);
    chk("d_dir_c4", 32'(dir), 32'd0);

    // arrive and a new call in the same cycle, then down sweep and reversal up
    cur_floor = 2'd0;
    call_req  = 4'b1000;
    push_exp(3, 1, 3);
    expect_issue("e_first");
    cur_floor = 2'd3;
    arrive    = 1'b1;
    call_req  = 4'b1010;
    tick();
    arrive    = 1'b0;
    call_req  = '0;
    chk("e_pending_sim", 32'(pending), 32'b0010);
    chk("e_served_sim", 32'(served), 32'd1);
    push_exp(1, 2, 1);
    expect_issue("e_next");
    call_req = 4'b1001;
    tick();
    call_req = '0;
    do_arrive(1);
    chk("e_pending2", 32'(pending), 32'b1001);
    push_exp(0, 2, 1);
    expect_issue("e_down");
    do_arrive(0);
    push_exp(3, 1, 1);
    expect_issue("e_reverse_up");
    do_arrive(3);
    chk("e_pending_end", 32'(pending), 32'd0);

    // reset while busy; arrive during and after reset is ignored
    cur_floor = 2'd0;
    call_req  = 4'b0100;
    push_exp(2, 1, 3);
    expect_issue("f_issue");
    rst_n  = 1'b0;
    arrive = 1'b1;
    tick();
    chk("f_valid_rst", 32'(tgt_valid), 32'd0);
    chk("f_pending_rst", 32'(pending), 32'd0);
    chk("f_dir_rst", 32'(dir), 32'd0);
    rst_n = 1'b1;
    tick();
    arrive = 1'b0;
    chk("f_served_after", 32'(served), 32'd0);
    chk("f_valid_after", 32'(tgt_valid), 32'd0);
    tick();
    chk("f_served_after2", 32'(served), 32'd0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
